// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM port arbiter and its helpers.
package psram_pkg;

  localparam int unsigned PSRAM_AW = 25;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WDATA,
    ST_RDATA,
    ST_GAP
  } psram_arb_state_t;

  // Latched transaction: direction and start address of the granted burst.
  typedef struct packed {
    logic                is_wr;
    logic [PSRAM_AW-1:0] addr;
  } psram_req_t;

endpackage

// File: rtl/psram_arb_rr_pick.sv
// Combinational round-robin selector: first requester after 'last', wrapping.
module rr_pick #(
  parameter  int unsigned NPORT = 2,
  localparam int unsigned IW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic [NPORT-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    grant,
  output logic             valid
);

  logic [IW-1:0] idx;

  always_comb begin
    grant = last;
    valid = 1'b0;
    idx   = last;
    for (int unsigned k = 1; k <= NPORT; k++) begin
      idx = IW'((32'(last) + k) % NPORT);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/psram_arb.sv
// Round-robin arbiter/sequencer sharing one PSRAM controller port among NPORT requesters.
// Optional data-phase timeout is enabled with the PSRAM_ARB_TIMEOUT_EN macro.
module psram_arb
  import psram_pkg::*;
#(
  parameter int unsigned NPORT    = 2,
  parameter int unsigned WR_BEATS = 8,
  parameter int unsigned RD_BEATS = 4,
  parameter int unsigned GAP_CYC  = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           psram_ready,
  input  logic [NPORT-1:0][PSRAM_AW-1:0] s_awaddr,
  input  logic [NPORT-1:0]               s_awvalid,
  output logic [NPORT-1:0]               s_awready,
  input  logic [NPORT-1:0][15:0]         s_wdata,
  input  logic [NPORT-1:0]               s_wvalid,
  output logic [NPORT-1:0]               s_wready,
  output logic [NPORT-1:0]               s_bvalid,
  output logic [NPORT-1:0][1:0]          s_bresp,
  input  logic [NPORT-1:0]               s_bready,
  input  logic [NPORT-1:0][PSRAM_AW-1:0] s_araddr,
  input  logic [NPORT-1:0]               s_arvalid,
  output logic [NPORT-1:0]               s_arready,
  output logic [15:0]                    s_rdata,
  output logic [NPORT-1:0]               s_rvalid,
  output logic                           s_rlast,
  output logic [1:0]                     s_rresp,
  output logic [PSRAM_AW-1:0]            m_awaddr,
  output logic [7:0]                     m_awlen,
  output logic                           m_awvalid,
  output logic [15:0]                    m_wdata,
  output logic                           m_wvalid,
  input  logic                           m_wready,
  output logic [PSRAM_AW-1:0]            m_araddr,
  output logic [7:0]                     m_arlen,
  output logic                           m_arvalid,
  input  logic [15:0]                    m_rdata,
  input  logic                           m_rvalid,
  output logic                           busy,
  output logic                           err
);

  localparam int unsigned IW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int unsigned BW = 4;
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
  localparam int unsigned LW = 8;

  if (NPORT < 2 || NPORT > 4 || WR_BEATS < 1 || WR_BEATS > 16 || RD_BEATS < 1 || RD_BEATS > 16 ||
      GAP_CYC < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("psram_arb: unsupported parameter set");
  end

  psram_arb_state_t         state_q, state_d;
  psram_req_t               req_q, req_d;
  logic [IW-1:0]            grant_q, grant_d;
  logic [IW-1:0]            last_q, last_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic [NPORT-1:0]         bvalid_q, bvalid_d;
  logic [NPORT-1:0][1:0]    bresp_q, bresp_d;
  logic [NPORT-1:0]         awready_q, awready_d;
  logic [NPORT-1:0]         arready_q, arready_d;
  logic                     awvalid_q, awvalid_d;
  logic                     arvalid_q, arvalid_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;

  logic [NPORT-1:0] elig;
  logic [IW-1:0]    pick;
  logic             pick_vld;
  logic             wr_beat, rd_beat, wr_done, rd_done, to_hit;

  // A port with an unacknowledged write response may only issue reads.
  assign elig = s_arvalid | (s_awvalid & ~bvalid_q);

  rr_pick #(.NPORT(NPORT)) u_rr_pick (
    .req   (elig),
    .last  (last_q),
    .grant (pick),
    .valid (pick_vld)
  );

  assign wr_beat = (state_q == ST_WDATA) && m_wready && s_wvalid[grant_q];
  assign rd_beat = (state_q == ST_RDATA) && m_rvalid;
  assign wr_done = wr_beat && (beat_q == BW'(WR_BEATS - 1));
  assign rd_done = rd_beat && (beat_q == BW'(RD_BEATS - 1));

`ifdef PSRAM_ARB_TIMEOUT_EN
  logic [7:0] to_q, to_d;

  always_comb begin
    to_d = to_q;
    if (state_q == ST_ISSUE) begin
      to_d = '0;
    end else if (state_q == ST_WDATA || state_q == ST_RDATA) begin
      to_d = to_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) to_q <= '0;
    else       to_q <= to_d;
  end

  assign to_hit = (state_q == ST_WDATA || state_q == ST_RDATA) && (to_q == 8'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Data-path steering toward the granted requester; these follow inputs with no latency.
  always_comb begin
    m_wdata  = '0;
    m_wvalid = 1'b0;
    s_wready = '0;
    s_rdata  = '0;
    s_rvalid = '0;
    s_rlast  = 1'b0;
    s_rresp  = RESP_OKAY;
    if (state_q == ST_WDATA) begin
      m_wdata           = s_wdata[grant_q];
      m_wvalid          = s_wvalid[grant_q];
      s_wready[grant_q] = m_wready;
    end
    if (state_q == ST_RDATA) begin
      s_rdata           = m_rdata;
      s_rvalid[grant_q] = m_rvalid;
      s_rlast           = rd_done;
      if (to_hit && !rd_done) begin
        s_rdata           = '0;
        s_rvalid[grant_q] = 1'b1;
        s_rlast           = 1'b1;
        s_rresp           = RESP_SLVERR;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    grant_d   = grant_q;
    last_d    = last_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    bvalid_d  = bvalid_q & ~s_bready;
    bresp_d   = bresp_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (psram_ready && pick_vld) begin
          grant_d     = pick;
          req_d.is_wr = !s_arvalid[pick];
          req_d.addr  = s_arvalid[pick] ? s_araddr[pick] : s_awaddr[pick];
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        last_d  = grant_q;
        beat_d  = '0;
        state_d = req_q.is_wr ? ST_WDATA : ST_RDATA;
      end
      ST_WDATA: begin
        if (wr_beat) beat_d = beat_q + BW'(1);
        if (wr_done || to_hit) begin
          bvalid_d[grant_q] = 1'b1;
          bresp_d[grant_q]  = wr_done ? RESP_OKAY : RESP_SLVERR;
          if (!wr_done) err_d = 1'b1;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_RDATA: begin
        if (rd_beat) beat_d = beat_q + BW'(1);
        if (rd_done || to_hit) begin
          if (!rd_done) err_d = 1'b1;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) state_d = ST_IDLE;
        else                           gap_d   = gap_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Issue pulses are registered off the next state so they line up with ISSUE.
    awvalid_d = (state_d == ST_ISSUE) && req_d.is_wr;
    arvalid_d = (state_d == ST_ISSUE) && !req_d.is_wr;
    awready_d = '0;
    arready_d = '0;
    if (state_d == ST_ISSUE) begin
      awready_d[grant_d] = req_d.is_wr;
      arready_d[grant_d] = !req_d.is_wr;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      grant_q   <= '0;
      last_q    <= IW'(NPORT - 1);
      beat_q    <= '0;
      gap_q     <= '0;
      bvalid_q  <= '0;
      bresp_q   <= '0;
      awready_q <= '0;
      arready_q <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      awvalid_q <= awvalid_d;
      arvalid_q <= arvalid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign s_awready = awready_q;
  assign s_arready = arready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign m_awaddr  = req_q.addr;
  assign m_araddr  = req_q.addr;
  assign m_awlen   = LW'(WR_BEATS - 1);
  assign m_arlen   = LW'(RD_BEATS - 1);
  assign m_awvalid = awvalid_q;
  assign m_arvalid = arvalid_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_psram_arb.sv
// Directed bench for psram_arb: write/read bursts, rotation, ready gating, bresp blocking, timeout.
module tb_psram_arb;
  import psram_pkg::*;

  localparam int unsigned NPORT = 2;

  logic clk = 1'b0;
  logic reset, psram_ready;
  logic [NPORT-1:0][PSRAM_AW-1:0] s_awaddr, s_araddr;
  logic [NPORT-1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [NPORT-1:0] s_arvalid, s_arready, s_rvalid;
  logic [NPORT-1:0][15:0] s_wdata;
  logic [NPORT-1:0][1:0] s_bresp;
  logic [15:0] s_rdata, m_wdata, m_rdata;
  logic s_rlast;
  logic [1:0] s_rresp;
  logic [PSRAM_AW-1:0] m_awaddr, m_araddr;
  logic [7:0] m_awlen, m_arlen;
  logic m_awvalid, m_wvalid, m_wready, m_arvalid, m_rvalid, busy, err;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  psram_arb #(.NPORT(NPORT), .WR_BEATS(8), .RD_BEATS(4), .GAP_CYC(4), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .psram_ready(psram_ready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rresp(s_rresp),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .busy(busy), .err(err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t required finish before 200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b required 0 within 40 cycles", tag, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; psram_ready = 1'b0;
    s_awaddr = '0; s_awvalid = '0; s_wdata = '0; s_wvalid = '0; s_bready = '0;
    s_araddr = '0; s_arvalid = '0; m_wready = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: busy=%b err=%b required 0 0", busy, err);
    end
    n_checks++;
    if ({m_awvalid, m_arvalid, m_wvalid, s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast} !== '0) begin
      n_fail++;
      $display("FAIL reset_valids: awv=%b arv=%b wv=%b awr=%b arr=%b wr=%b bv=%b rv=%b rl=%b required all 0",
               m_awvalid, m_arvalid, m_wvalid, s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast);
    end
    n_checks++;
    if (m_awlen !== 8'd7 || m_arlen !== 8'd3) begin
      n_fail++; $display("FAIL reset_len: awlen=%0d arlen=%0d required 7 3", m_awlen, m_arlen);
    end
    n_checks++;
    if (m_awaddr !== '0 || m_araddr !== '0 || m_wdata !== '0 || s_rdata !== '0 || s_bresp !== '0 || s_rresp !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h rdata=%h bresp=%h rresp=%b required all 0",
               m_awaddr, m_araddr, m_wdata, s_rdata, s_bresp, s_rresp);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write();
    int bad;
    @(negedge clk);
    psram_ready = 1'b1;
    s_awaddr[0] = 25'h000100; s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_wdata[0] = 16'h1000;
    @(negedge clk); #1;
    n_checks++;
    if (m_awvalid !== 1'b1 || m_awaddr !== 25'h000100 || m_awlen !== 8'd7 || s_awready !== 2'b01 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_issue: awvalid=%b awaddr=%h awlen=%0d awready=%b busy=%b required 1 000100 7 01 1",
               m_awvalid, m_awaddr, m_awlen, s_awready, busy);
    end
    s_awvalid[0] = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_wdata[0] = 16'h1000 + 16'(i); m_wready = 1'b1;
      #1;
      if (m_awvalid !== 1'b0 || m_wdata !== 16'h1000 + 16'(i) || m_wvalid !== 1'b1 ||
          s_wready !== 2'b01 || s_bvalid !== 2'b00) begin
        bad++;
        $display("FAIL wr_beat%0d: awvalid=%b wdata=%h wvalid=%b wready=%b bvalid=%b required 0 %h 1 01 00",
                 i, m_awvalid, m_wdata, m_wvalid, s_wready, s_bvalid, 16'h1000 + 16'(i));
      end
    end
    n_checks++;
    if (bad != 0) n_fail++;
    @(negedge clk);
    m_wready = 1'b0; s_wvalid[0] = 1'b0; s_bready[0] = 1'b1;
    #1;
    n_checks++;
    if (s_bvalid !== 2'b01 || s_bresp[0] !== 2'b00 || m_wvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_bresp: bvalid=%b bresp0=%b wvalid=%b required 01 00 0", s_bvalid, s_bresp[0], m_wvalid);
    end
    @(negedge clk);
    s_bready[0] = 1'b0;
    #1;
    n_checks++;
    if (s_bvalid !== 2'b00) begin
      n_fail++; $display("FAIL wr_bclear: bvalid=%b required 00", s_bvalid);
    end
    wait_idle("wr");
  endtask

  task automatic test_read();
    int b;
    int bad;
    @(negedge clk);
    s_araddr[1] = 25'h000040; s_arvalid[1] = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== 25'h000040 || m_arlen !== 8'd3 || s_arready !== 2'b10 || m_awvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_issue: arvalid=%b araddr=%h arlen=%0d arready=%b awvalid=%b required 1 000040 3 10 0",
               m_arvalid, m_araddr, m_arlen, s_arready, m_awvalid);
    end
    s_arvalid[1] = 1'b0;
    b = 0; bad = 0;
    // One idle controller cycle mid-burst: beats, not cycles, end the burst.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_rvalid = (i != 2); m_rdata = 16'h00A0 + 16'(b);
      #1;
      if (s_rvalid !== ((i != 2) ? 2'b10 : 2'b00) || (i != 2 && s_rdata !== 16'h00A0 + 16'(b)) ||
          s_rlast !== (i == 4) || s_rresp !== 2'b00) begin
        bad++;
        $display("FAIL rd_cycle%0d: rvalid=%b rdata=%h rlast=%b rresp=%b required %b %h %b 00",
                 i, s_rvalid, s_rdata, s_rlast, s_rresp, (i != 2) ? 2'b10 : 2'b00, 16'h00A0 + 16'(b), (i == 4));
      end
      if (i != 2) b++;
    end
    n_checks++;
    if (bad != 0) n_fail++;
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    n_checks++;
    if (s_rvalid !== 2'b00 || s_rlast !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rd_after: rvalid=%b rlast=%b busy=%b required 00 0 1", s_rvalid, s_rlast, busy);
    end
    wait_idle("rd");
  endtask

  task automatic test_round_robin();
    int pulse_cyc[4];
    logic [1:0] pulse_port[4];
    logic [1:0] exp_port[4];
    int np;
    int rd_left;
    int bad;
    exp_port = '{2'b01, 2'b10, 2'b01, 2'b10};
    np = 0; rd_left = 0; bad = 0;
    @(negedge clk);
    s_araddr[0] = 25'h000200; s_araddr[1] = 25'h000300; s_arvalid = 2'b11;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      m_rvalid = (rd_left > 0); m_rdata = 16'(c);
      if (rd_left > 0) rd_left--;
      #1;
      if (m_arvalid === 1'b1) begin
        if (np < 4) begin
          pulse_cyc[np] = c; pulse_port[np] = s_arready;
          if (m_araddr !== ((s_arready == 2'b10) ? 25'h000300 : 25'h000200)) begin
            bad++; $display("FAIL rr_addr%0d: araddr=%h arready=%b", np, m_araddr, s_arready);
          end
        end
        np++; rd_left = 4;
        if (np == 4) s_arvalid = 2'b00;
      end
    end
    n_checks++;
    if (np != 4) begin
      n_fail++; $display("FAIL rr_count: pulses=%0d required 4", np);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pulse_port[i] !== exp_port[i]) begin
          bad++; $display("FAIL rr_grant%0d: arready=%b required %b", i, pulse_port[i], exp_port[i]);
        end
        if (i > 0 && pulse_cyc[i] - pulse_cyc[i-1] != 10) begin
          bad++; $display("FAIL rr_spacing%0d: cycles=%0d required 10", i, pulse_cyc[i] - pulse_cyc[i-1]);
        end
      end
    end
    n_checks++;
    if (bad != 0) n_fail++;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rr_end: busy=%b required 0", busy);
    end
  endtask

  task automatic test_ready_gate();
    int bad;
    @(negedge clk);
    psram_ready = 1'b0; s_araddr[0] = 25'h000123; s_arvalid[0] = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (m_arvalid !== 1'b0 || m_awvalid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL gate_hold%0d: arvalid=%b awvalid=%b busy=%b required 0 0 0", i, m_arvalid, m_awvalid, busy);
      end
    end
    n_checks++;
    if (bad != 0) n_fail++;
    @(negedge clk);
    psram_ready = 1'b1;
    #1;
    n_checks++;
    if (m_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL gate_raise: arvalid=%b required 0", m_arvalid);
    end
    @(negedge clk); #1;
    n_checks++;
    if (m_arvalid !== 1'b1 || s_arready !== 2'b01 || m_araddr !== 25'h000123) begin
      n_fail++; $display("FAIL gate_issue: arvalid=%b arready=%b araddr=%h required 1 01 000123", m_arvalid, s_arready, m_araddr);
    end
    s_arvalid[0] = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_rvalid = 1'b1; m_rdata = 16'h5A00 + 16'(i);
      if (i == 1) psram_ready = 1'b0;
      #1;
      if (s_rvalid !== 2'b01 || s_rdata !== 16'h5A00 + 16'(i) || s_rlast !== (i == 3)) begin
        bad++; $display("FAIL gate_beat%0d: rvalid=%b rdata=%h rlast=%b required 01 %h %b", i, s_rvalid, s_rdata, s_rlast, 16'h5A00 + 16'(i), (i == 3));
      end
    end
    n_checks++;
    if (bad != 0) n_fail++;
    @(negedge clk);
    m_rvalid = 1'b0; psram_ready = 1'b1;
    wait_idle("gate");
  endtask

  task automatic test_bresp_block();
    int bad;
    bit seen;
    @(negedge clk);
    s_awaddr[0] = 25'h000400; s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_wdata[0] = 16'hBEEF;
    @(negedge clk); #1;
    n_checks++;
    if (m_awvalid !== 1'b1 || s_awready !== 2'b01) begin
      n_fail++; $display("FAIL blk_wr1: awvalid=%b awready=%b required 1 01", m_awvalid, s_awready);
    end
    s_awvalid[0] = 1'b0;
    repeat (8) begin @(negedge clk); m_wready = 1'b1; end
    @(negedge clk);
    m_wready = 1'b0;
    s_arvalid[0] = 1'b1; s_araddr[0] = 25'h000500; s_awvalid[0] = 1'b1; s_awaddr[0] = 25'h000600;
    #1;
    n_checks++;
    if (s_bvalid !== 2'b01) begin
      n_fail++; $display("FAIL blk_bvalid: bvalid=%b required 01", s_bvalid);
    end
    seen = 1'b0; bad = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      if (m_awvalid !== 1'b0) begin
        bad++; $display("FAIL blk_early_aw: awvalid=%b required 0", m_awvalid);
      end
      if (m_arvalid === 1'b1) begin
        seen = 1'b1;
        if (s_arready !== 2'b01 || m_araddr !== 25'h000500) begin
          bad++; $display("FAIL blk_rd: arready=%b araddr=%h required 01 000500", s_arready, m_araddr);
        end
        s_arvalid[0] = 1'b0;
      end
    end
    n_checks++;
    if (!seen || bad != 0) begin
      n_fail++; $display("FAIL blk_rd_grant: seen=%b errors=%0d required 1 0", seen, bad);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      m_rvalid = (i < 4);
      #1;
      if (m_awvalid !== 1'b0 || s_bvalid !== 2'b01) begin
        bad++; $display("FAIL blk_wait%0d: awvalid=%b bvalid=%b required 0 01", i, m_awvalid, s_bvalid);
      end
    end
    n_checks++;
    if (bad != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL blk_hold: errors=%0d busy=%b required 0 0", bad, busy);
    end
    @(negedge clk);
    s_bready[0] = 1'b1;
    @(negedge clk);
    s_bready[0] = 1'b0;
    #1;
    n_checks++;
    if (s_bvalid !== 2'b00 || m_awvalid !== 1'b0) begin
      n_fail++; $display("FAIL blk_ack: bvalid=%b awvalid=%b required 00 0", s_bvalid, m_awvalid);
    end
    @(negedge clk); #1;
    n_checks++;
    if (m_awvalid !== 1'b1 || m_awaddr !== 25'h000600 || s_awready !== 2'b01) begin
      n_fail++; $display("FAIL blk_wr2: awvalid=%b awaddr=%h awready=%b required 1 000600 01", m_awvalid, m_awaddr, s_awready);
    end
    s_awvalid[0] = 1'b0;
    repeat (8) begin @(negedge clk); m_wready = 1'b1; end
    @(negedge clk);
    m_wready = 1'b0; s_wvalid[0] = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (s_bvalid !== 2'b01 || busy !== 1'b1) begin
      n_fail++; $display("FAIL blk_wr2_done: bvalid=%b busy=%b required 01 1", s_bvalid, busy);
    end
    @(negedge clk); #1;
    n_checks++;
    if (s_bvalid !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL blk_reset: bvalid=%b busy=%b required 00 0", s_bvalid, busy);
    end
    reset = 1'b0;
  endtask

`ifdef PSRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int bad;
    @(negedge clk);
    s_araddr[1] = 25'h000777; s_arvalid[1] = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (m_arvalid !== 1'b1 || s_arready !== 2'b10) begin
      n_fail++; $display("FAIL to_issue: arvalid=%b arready=%b required 1 10", m_arvalid, s_arready);
    end
    s_arvalid[1] = 1'b0;
    bad = 0;
    for (int j = 1; j <= 254; j++) begin
      @(negedge clk); #1;
      if (s_rvalid !== 2'b00 || err !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL to_wait: early cycles=%0d required 0", bad);
    end
    @(negedge clk); #1;
    n_checks++;
    if (s_rvalid !== 2'b10 || s_rlast !== 1'b1 || s_rresp !== 2'b10 || s_rdata !== 16'h0000) begin
      n_fail++; $display("FAIL to_beat: rvalid=%b rlast=%b rresp=%b rdata=%h required 10 1 10 0000", s_rvalid, s_rlast, s_rresp, s_rdata);
    end
    @(negedge clk); #1;
    n_checks++;
    if (err !== 1'b1 || s_rvalid !== 2'b00 || busy !== 1'b1) begin
      n_fail++; $display("FAIL to_err: err=%b rvalid=%b busy=%b required 1 00 1", err, s_rvalid, busy);
    end
    wait_idle("to");
    @(negedge clk);
    s_araddr[0] = 25'h000888; s_arvalid[0] = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (m_arvalid !== 1'b1 || s_arready !== 2'b01) begin
      n_fail++; $display("FAIL to_next: arvalid=%b arready=%b required 1 01", m_arvalid, s_arready);
    end
    s_arvalid[0] = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_rvalid = 1'b1; m_rdata = 16'hC0 + 16'(i);
      #1;
      if (s_rvalid !== 2'b01 || s_rresp !== 2'b00 || s_rlast !== (i == 3) || err !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL to_next_beats: bad beats=%0d required 0", bad);
    end
    @(negedge clk);
    m_rvalid = 1'b0;
    wait_idle("to_next");
  endtask
`else
  task automatic test_err_tied();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_tied: err=%b required 0", err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_ready_gate();
    test_bresp_block();
`ifdef PSRAM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_err_tied();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
